// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the slave memory.
// The optional range check is enabled by defining AXI_SLAVE_RANGE_CHECK_EN.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } t_burst;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } t_resp;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } t_wstate;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } t_rstate;

    // WRAP (and the reserved 2'b11) step like INCR; only FIXED holds the index.
    function automatic logic burst_is_fixed(input logic [1:0] burst);
        return burst == FIXED;
    endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI4 write/read channel bundle between the core's master and the slave memory.
interface axi_slave_mem_if #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32
);
    logic                        AW_VALID, AW_READY;
    logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR;
    logic [7:0]                  AW_LEN;
    logic [2:0]                  AW_SIZE, AW_PROT;
    logic [1:0]                  AW_BURST;

    logic                        W_VALID, W_READY, W_LAST;
    logic [AXI_DATA_WIDTH-1:0]   W_DATA;
    logic [AXI_DATA_WIDTH/8-1:0] W_STRB;

    logic                        B_VALID, B_READY;
    logic [1:0]                  B_RESP;

    logic                        AR_VALID, AR_READY;
    logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR;
    logic [7:0]                  AR_LEN;
    logic [2:0]                  AR_SIZE, AR_PROT;
    logic [1:0]                  AR_BURST;

    logic                        R_VALID, R_READY, R_LAST;
    logic [AXI_DATA_WIDTH-1:0]   R_DATA;
    logic [1:0]                  R_RESP;

    modport master (
        output AW_VALID, AW_ADDR, AW_LEN, AW_SIZE, AW_BURST, AW_PROT,
        output W_VALID, W_DATA, W_STRB, W_LAST, B_READY,
        output AR_VALID, AR_ADDR, AR_LEN, AR_SIZE, AR_BURST, AR_PROT, R_READY,
        input  AW_READY, W_READY, B_VALID, B_RESP,
        input  AR_READY, R_VALID, R_DATA, R_RESP, R_LAST
    );

    modport slave (
        input  AW_VALID, AW_ADDR, AW_LEN, AW_SIZE, AW_BURST, AW_PROT,
        input  W_VALID, W_DATA, W_STRB, W_LAST, B_READY,
        input  AR_VALID, AR_ADDR, AR_LEN, AR_SIZE, AR_BURST, AR_PROT, R_READY,
        output AW_READY, W_READY, B_VALID, B_RESP,
        output AR_READY, R_VALID, R_DATA, R_RESP, R_LAST
    );
endinterface

// File: rtl/axi_slave_ram.sv
// Word RAM with one byte-enabled write port and one registered read port.
module axi_slave_ram #(
    parameter int MEM_DEPTH      = 1024,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic                          we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0]  waddr_i,
    input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_i,
    input  logic                          re_i,
    input  logic [$clog2(MEM_DEPTH)-1:0]  raddr_i,
    output logic [AXI_DATA_WIDTH-1:0]     rdata_o
);
    localparam int NB = AXI_DATA_WIDTH / 8;

    logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto RAM macros; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // A read colliding with a write to the same word returns the pre-write word.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave RAM with independent write (AW/W/B) and read (AR/R) FSMs.
// Define AXI_SLAVE_RANGE_CHECK_EN to answer out-of-range bursts with SLVERR.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 1024
) (
    input logic            clk,
    input logic            arstn,
    axi_slave_mem_if.slave s
);
    localparam int NB    = AXI_DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int TOP   = OFF_W + IDX_W;

    logic [IDX_W-1:0] aw_idx, ar_idx, ram_raddr;
    logic             aw_oor, ar_oor, ram_we, ram_re;
    logic [AXI_DATA_WIDTH-1:0] ram_rdata;

    t_wstate    w_state_q, w_state_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic [7:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic       w_fixed_q, w_fixed_d, w_err_q, w_err_d;

    t_rstate    r_state_q, r_state_d;
    logic [IDX_W-1:0] r_idx_q, r_idx_d, r_next;
    logic [7:0] r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic       r_fixed_q, r_fixed_d, r_err_q, r_err_d;

    assign aw_idx = s.AW_ADDR[TOP-1:OFF_W];
    assign ar_idx = s.AR_ADDR[TOP-1:OFF_W];

`ifdef AXI_SLAVE_RANGE_CHECK_EN
    assign aw_oor = |s.AW_ADDR[AXI_ADDR_WIDTH-1:TOP];
    assign ar_oor = |s.AR_ADDR[AXI_ADDR_WIDTH-1:TOP];
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // Size, protection and W_LAST carry no meaning for this memory.
    logic unused_ok;
    assign unused_ok = ^{s.AW_SIZE, s.AW_PROT, s.AR_SIZE, s.AR_PROT, s.W_LAST,
                         s.AW_ADDR, s.AR_ADDR};

    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_fixed_d = w_fixed_q;
        w_err_d   = w_err_q;
        ram_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (s.AW_VALID) begin
                w_idx_d   = aw_idx;
                w_len_d   = s.AW_LEN;
                w_fixed_d = burst_is_fixed(s.AW_BURST);
                w_err_d   = aw_oor;
                w_cnt_d   = 8'd0;
                w_state_d = W_DATA;
            end
            W_DATA: if (s.W_VALID) begin
                ram_we = !w_err_q;
                if (w_cnt_q == w_len_q) begin
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q + 8'd1;
                    w_idx_d = w_fixed_q ? w_idx_q : w_idx_q + 1'b1;
                end
            end
            W_RESP:  if (s.B_READY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    assign r_next = r_fixed_q ? r_idx_q : r_idx_q + 1'b1;

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_fixed_d = r_fixed_q;
        r_err_d   = r_err_q;
        ram_re    = 1'b0;
        ram_raddr = r_idx_q;
        case (r_state_q)
            R_IDLE: if (s.AR_VALID) begin
                ram_re    = 1'b1;
                ram_raddr = ar_idx;
                r_idx_d   = ar_idx;
                r_len_d   = s.AR_LEN;
                r_fixed_d = burst_is_fixed(s.AR_BURST);
                r_err_d   = ar_oor;
                r_cnt_d   = 8'd0;
                r_state_d = R_DATA;
            end
            R_DATA: if (s.R_READY) begin
                if (r_cnt_q == r_len_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    ram_re    = 1'b1;
                    ram_raddr = r_next;
                    r_idx_d   = r_next;
                    r_cnt_d   = r_cnt_q + 8'd1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_fixed_q <= 1'b0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_fixed_q <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_fixed_q <= w_fixed_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_fixed_q <= r_fixed_d;
            r_err_q   <= r_err_d;
        end
    end

    axi_slave_ram #(
        .MEM_DEPTH      (MEM_DEPTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .arstn   (arstn),
        .we_i    (ram_we),
        .waddr_i (w_idx_q),
        .wdata_i (s.W_DATA),
        .wstrb_i (s.W_STRB),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign s.AW_READY = (w_state_q == W_IDLE);
    assign s.W_READY  = (w_state_q == W_DATA);
    assign s.B_VALID  = (w_state_q == W_RESP);
    assign s.B_RESP   = (w_state_q == W_RESP && w_err_q) ? SLVERR : OKAY;

    assign s.AR_READY = (r_state_q == R_IDLE);
    assign s.R_VALID  = (r_state_q == R_DATA);
    assign s.R_LAST   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
    assign s.R_RESP   = (r_state_q == R_DATA && r_err_q) ? SLVERR : OKAY;
    assign s.R_DATA   = r_err_q ? '0 : ram_rdata;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed plus randomized bench for axi_slave_mem against an array model of the RAM.
module tb_axi_slave_mem;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] dq[$];
    logic [3:0]  sq[$];

    always #5 clk = ~clk;

    axi_slave_mem_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

    axi_slave_mem #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .arstn (arstn),
        .s     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [63:0] addr, input int beat, input logic [1:0] burst);
        int base = int'(addr[11:2]);
        return (burst == 2'b00) ? base : (base + beat) % DEPTH;
    endfunction

    function automatic bit oor(input logic [63:0] addr);
`ifdef AXI_SLAVE_RANGE_CHECK_EN
        return addr[63:12] != 52'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic rdy(input int ch);
        case (ch)
            0:       return bus.AW_READY;
            1:       return bus.W_READY;
            default: return bus.AR_READY;
        endcase
    endfunction

    task automatic handshake(input string tag, input int ch);
        int n = 0;
        while (!rdy(ch) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, rdy(ch), 1);
        @(posedge clk); #1;
    endtask

    task automatic write_burst(input logic [63:0] addr, input int len, input logic [1:0] burst,
                               input logic [31:0] data[$], input logic [3:0] strb[$],
                               input int bstall);
        bit bad = oor(addr);
        bus.AW_ADDR  = addr;
        bus.AW_LEN   = 8'(len);
        bus.AW_BURST = burst;
        bus.AW_VALID = 1'b1;
        handshake("aw_ready", 0);
        bus.AW_VALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            bus.W_DATA  = data[b];
            bus.W_STRB  = strb[b];
            bus.W_LAST  = (b == len);
            bus.W_VALID = 1'b1;
            handshake("w_ready", 1);
            if (!bad) begin
                for (int k = 0; k < 4; k++)
                    if (strb[b][k]) model[widx(addr, b, burst)][k*8 +: 8] = data[b][k*8 +: 8];
            end
        end
        bus.W_VALID = 1'b0;
        chk("b_valid", bus.B_VALID, 1);
        chk("b_resp", bus.B_RESP, bad ? 2'b10 : 2'b00);
        for (int i = 0; i < bstall; i++) begin
            @(posedge clk); #1;
            chk("b_hold", bus.B_VALID, 1);
        end
        bus.B_READY = 1'b1;
        @(posedge clk); #1;
        bus.B_READY = 1'b0;
        chk("b_done", bus.B_VALID, 0);
    endtask

    task automatic read_burst(input logic [63:0] addr, input int len, input logic [1:0] burst,
                              input logic [31:0] pat);
        bit bad = oor(addr);
        int b = 0;
        int cyc = 0;
        bus.AR_ADDR  = addr;
        bus.AR_LEN   = 8'(len);
        bus.AR_BURST = burst;
        bus.AR_VALID = 1'b1;
        chk("r_idle_valid", bus.R_VALID, 0);
        handshake("ar_ready", 2);
        bus.AR_VALID = 1'b0;
        while (b <= len && cyc < 3000) begin
            bus.R_READY = pat[cyc % 32];
            chk("r_valid", bus.R_VALID, 1);
            chk("r_data", bus.R_DATA, bad ? 32'h0 : model[widx(addr, b, burst)]);
            chk("r_last", bus.R_LAST, (b == len));
            chk("r_resp", bus.R_RESP, bad ? 2'b10 : 2'b00);
            @(posedge clk); #1;
            if (bus.R_READY) b++;
            cyc++;
        end
        bus.R_READY = 1'b0;
        chk("r_end_valid", bus.R_VALID, 0);
        chk("r_beats", 64'(b), 64'(len + 1));
    endtask

    task automatic fill(input int len, input logic [31:0] first, input bit rnd, input logic [3:0] strb);
        dq = {};
        sq = {};
        for (int i = 0; i <= len; i++) begin
            dq.push_back(rnd ? $urandom : first + 32'(i));
            sq.push_back(strb);
        end
    endtask

    initial begin
        logic [63:0] a;
        logic [31:0] old_v;
        int len;
        logic [1:0] br;

        bus.AW_VALID = 0; bus.AW_ADDR = 0; bus.AW_LEN = 0; bus.AW_SIZE = 3'd2;
        bus.AW_BURST = 2'b01; bus.AW_PROT = 0;
        bus.W_VALID = 0; bus.W_DATA = 0; bus.W_STRB = 0; bus.W_LAST = 0; bus.B_READY = 0;
        bus.AR_VALID = 0; bus.AR_ADDR = 0; bus.AR_LEN = 0; bus.AR_SIZE = 3'd2;
        bus.AR_BURST = 2'b01; bus.AR_PROT = 0; bus.R_READY = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_aw_ready", bus.AW_READY, 1);
        chk("rst_ar_ready", bus.AR_READY, 1);
        chk("rst_w_ready", bus.W_READY, 0);
        chk("rst_b_valid", bus.B_VALID, 0);
        chk("rst_r_valid", bus.R_VALID, 0);
        chk("rst_r_last", bus.R_LAST, 0);
        chk("rst_b_resp", bus.B_RESP, 0);
        chk("rst_r_resp", bus.R_RESP, 0);
        chk("rst_r_data", bus.R_DATA, 0);
        arstn = 1'b1;
        @(posedge clk); #1;

        // Fill the whole RAM with known data; the 0xF00 burst is 256 beats and wraps past the top.
        for (int i = 1; i < 4; i++) begin
            fill(255, 0, 1, 4'hF);
            write_burst(64'(i * 32'h400), 255, 2'b01, dq, sq, 0);
        end
        fill(255, 0, 1, 4'hF);
        write_burst(64'h0F00, 255, 2'b01, dq, sq, 0);
        fill(63, 0, 1, 4'hF);
        write_burst(64'h0300, 63, 2'b01, dq, sq, 0);
        read_burst(64'h0F00, 255, 2'b01, 32'hFFFF_FFFF);

        fill(0, 32'hDEAD_BEEF, 0, 4'hF);
        write_burst(64'h10, 0, 2'b01, dq, sq, 0);
        read_burst(64'h10, 0, 2'b01, 32'hFFFF_FFFF);

        fill(3, 32'd1, 0, 4'hF);
        write_burst(64'h100, 3, 2'b01, dq, sq, 0);
        read_burst(64'h100, 3, 2'b01, 32'hFFFF_FFFF);

        fill(0, 32'hFFFF_FFFF, 0, 4'hF);
        write_burst(64'h200, 0, 2'b01, dq, sq, 0);
        fill(0, 32'h0, 0, 4'b0101);
        write_burst(64'h200, 0, 2'b01, dq, sq, 5);
        read_burst(64'h200, 0, 2'b01, 32'hFFFF_FFFF);

        read_burst(64'h100, 1, 2'b01, 32'h0000_0009);

        fill(3, 32'hA0, 0, 4'hF);
        write_burst(64'h40, 3, 2'b00, dq, sq, 0);
        read_burst(64'h40, 2, 2'b00, 32'hFFFF_FFFF);
        read_burst(64'h3C, 2, 2'b11, 32'hFFFF_FFFF);

        for (int it = 0; it < 12; it++) begin
            a = {52'd0, 12'($urandom)};
            if ($urandom_range(0, 3) == 0) a[63:12] = {$urandom, 20'($urandom)};
            len = $urandom_range(0, 7);
            br  = 2'($urandom);
            dq = {};
            sq = {};
            for (int i = 0; i <= len; i++) begin
                dq.push_back($urandom);
                sq.push_back(4'($urandom));
            end
            write_burst(a, len, br, dq, sq, $urandom_range(0, 2));
            read_burst(a, len, br, $urandom | 32'h1111_1111);
        end

        fill(0, 32'h1234_5678, 0, 4'hF);
        write_burst(64'h1_0000_0000, 0, 2'b01, dq, sq, 0);
        read_burst(64'h0, 0, 2'b01, 32'hFFFF_FFFF);
        read_burst(64'h1_0000_0000, 0, 2'b01, 32'hFFFF_FFFF);

        // Write beat and AR hit the same word on the same edge.
        old_v = model[32];
        bus.AW_ADDR = 64'h80; bus.AW_LEN = 0; bus.AW_BURST = 2'b01; bus.AW_VALID = 1'b1;
        handshake("c_aw_ready", 0);
        bus.AW_VALID = 1'b0;
        bus.W_DATA = ~old_v; bus.W_STRB = 4'hF; bus.W_LAST = 1'b1; bus.W_VALID = 1'b1;
        bus.AR_ADDR = 64'h80; bus.AR_LEN = 0; bus.AR_BURST = 2'b01; bus.AR_VALID = 1'b1;
        chk("c_w_ready", bus.W_READY, 1);
        chk("c_ar_ready", bus.AR_READY, 1);
        @(posedge clk); #1;
        bus.W_VALID = 1'b0;
        bus.AR_VALID = 1'b0;
        model[32] = ~old_v;
        chk("c_r_valid", bus.R_VALID, 1);
        chk("c_r_old", bus.R_DATA, old_v);
        chk("c_r_last", bus.R_LAST, 1);
        bus.R_READY = 1'b1; bus.B_READY = 1'b1;
        @(posedge clk); #1;
        bus.R_READY = 1'b0; bus.B_READY = 1'b0;
        chk("c_r_done", bus.R_VALID, 0);
        chk("c_b_done", bus.B_VALID, 0);
        read_burst(64'h80, 0, 2'b01, 32'hFFFF_FFFF);

        // Reset while beat 2 of a 4-beat write is on the bus.
        bus.AW_ADDR = 64'h500; bus.AW_LEN = 3; bus.AW_BURST = 2'b01; bus.AW_VALID = 1'b1;
        handshake("x_aw_ready", 0);
        bus.AW_VALID = 1'b0;
        bus.W_DATA = 32'hCAFE_0001; bus.W_STRB = 4'hF; bus.W_LAST = 1'b0; bus.W_VALID = 1'b1;
        handshake("x_w0_ready", 1);
        model[320] = 32'hCAFE_0001;
        bus.W_DATA = 32'hCAFE_0002;
        #1 arstn = 1'b0;
        #1;
        chk("x_aw_ready", bus.AW_READY, 1);
        chk("x_w_ready", bus.W_READY, 0);
        chk("x_b_valid", bus.B_VALID, 0);
        chk("x_r_valid", bus.R_VALID, 0);
        bus.W_VALID = 1'b0;
        @(posedge clk); #1;
        arstn = 1'b1;
        @(posedge clk); #1;
        chk("x_b_after", bus.B_VALID, 0);
        read_burst(64'h500, 1, 2'b01, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
